taillight_sequencer: RTL and testbench
======================================

// Module: taillight_sequencer
// PURPOSE
//  Sequencing controller for the six-lamp taillight bank (3 left, 3 right) on the DE10-Lite LEDs.
//  Arbitrates hazard, turn and brake requests from the switch/key inputs into one lamp mode.
//  Steps the lamp patterns on a prescaled tick derived from the 10 MHz board clock.
//  Sits between the input conditioning and the LEDR mapping in the top level.
// PARAMETERS
//  DIV   5_000_000   ADC_CLK_10 cycles per pattern step (2 Hz at 10 MHz); benches use DIV=4
//  CW    23          prescaler counter width; must satisfy 2**CW >= DIV
// PORTS
//  ADC_CLK_10  in   1  10 MHz board clock; all state on rising edge
//  RESET       in   1  asynchronous, active-high reset
//  hazard_req  in   1  hazard flasher request (SW[0])
//  turn_req    in   1  turn signal request (SW[1])
//  turn_dir    in   1  1 = left, 0 = right (KEY[1])
//  brake_req   in   1  brake request (SW[2])
//  lamp_l      out  3  left lamps; bit0 inner, bit2 outer
//  lamp_r      out  3  right lamps; bit0 inner, bit2 outer
//  mode        out  2  registered mode: 00 IDLE, 01 HAZ, 10 LEFT, 11 RIGHT
//  step_tick   out  1  one-cycle pulse when the pattern advances
// BEHAVIOUR
//  - Reset (async, immediate): mode=00, phase=0, brake_q=0, prescaler=0 -> lamp_l=lamp_r=000, step_tick=0.
//  - Mode decode, fixed priority: hazard_req > turn_req (LEFT/RIGHT by turn_dir) > IDLE.
//    brake_req is not a mode; it is registered into brake_q every cycle.
//  - Latency: a request change sampled at edge N updates mode/brake_q at edge N; outputs are
//    a combinational function of registered mode, phase and brake_q only (no input-to-output path).
//  - Mode change (decoded != mode): at that edge mode loads new value, phase->0, prescaler->0.
//    A brake_q change alone never resets phase or prescaler.
//  - Prescaler: runs only in HAZ/LEFT/RIGHT; counts 0..DIV-1, wraps to 0; step_tick=1 for the
//    cycle count==DIV-1; phase advances on the edge ending that cycle. Held at 0 in IDLE.
//  - phase[1:0]: LEFT/RIGHT cycle 0->1->2->3->0; HAZ toggles 0<->1 only; IDLE holds 0.
//  - Turning-side pattern by phase: 0:001 1:011 2:111 3:000 (wraps to 001).
//  - Non-turning side: 111 if brake_q else 000.
//  - HAZ: both sides 111 at phase 0, 000 at phase 1; brake_q ignored while in HAZ.
//  - IDLE: both sides 111 if brake_q else 000.
//  - turn_dir flip while turning = mode change (restart at phase 0 on new side; old side -> brake/off).
//  - Reset mid-sequence: immediate blank; after release, requests still held restart at phase 0.
// CONFIGURATION
//  TS_SYNC_EN defined: the four request inputs pass through 2-flop synchronizers (reset to 0)
//    before decode; request-to-mode latency becomes 3 edges (sync, sync, mode).
//  TS_SYNC_EN undefined: inputs decoded directly; request-to-mode latency 1 edge.
//  All other behaviour identical.
// TESTING (DIV=4, TS_SYNC_EN undefined unless stated)
//  1 RESET=1 mid-clock, no edge -> lamp_l=lamp_r=000, mode=00, step_tick=0 immediately.
//  2 turn_req=1,turn_dir=1 at edge 0 -> mode=10, lamp_l=001 after edge 0; step_tick at cycle 3;
//    lamp_l=011 after edge 4, 111 after 8, 000 after 12, 001 after 16; lamp_r=000 throughout.
//  3 As 2, brake_req=1 at edge 6 -> lamp_r=111 from edge 6; lamp_l still 111 after edge 8 (no restart).
//  4 RIGHT at phase 2, hazard_req=1 -> next edge mode=01, both 111; 000 after +4 edges, 111 after +8;
//    drop hazard_req -> next edge mode=11, lamp_r=001.
//  5 LEFT at phase 2, pulse RESET -> lamps 000 at once; release with turn_req held -> lamp_l=001
//    after first edge, sequence resumes as in 2.
//  6 TS_SYNC_EN defined, turn_req 0->1 before edge 0 -> mode=10 and lamp_l=001 only after edge 2.

Source files
------------

// File: rtl/taillight_sequencer.sv
// Six-lamp taillight sequencer: arbitrates hazard/turn/brake requests and steps lamp patterns on a prescaled tick.
// Optional feature: define TS_SYNC_EN to pass the four request inputs through 2-flop synchronizers.
module taillight_sequencer #(
   parameter int DIV = 5_000_000,
   parameter int CW  = 23
) (
   input  logic       ADC_CLK_10,
   input  logic       RESET,
   input  logic       hazard_req,
   input  logic       turn_req,
   input  logic       turn_dir,
   input  logic       brake_req,
   output logic [2:0] lamp_l,
   output logic [2:0] lamp_r,
   output logic [1:0] mode,
   output logic       step_tick
);

   typedef enum logic [1:0] {
      M_IDLE  = 2'b00,
      M_HAZ   = 2'b01,
      M_LEFT  = 2'b10,
      M_RIGHT = 2'b11
   } mode_t;

   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic          hz, tr, td, br;
   mode_t         state, state_nxt, decoded;
   logic [1:0]    phase, phase_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          brake_q;
   logic [2:0]    turn_pat;

`ifdef TS_SYNC_EN
   logic [3:0] sync1, sync2;

   // Two-stage synchronizer for the asynchronous switch/key requests
   always_ff @(posedge ADC_CLK_10 or posedge RESET) begin
      if (RESET) begin
         sync1 <= 4'b0000;
         sync2 <= 4'b0000;
      end else begin
         sync1 <= {hazard_req, turn_req, turn_dir, brake_req};
         sync2 <= sync1;
      end
   end

   assign {hz, tr, td, br} = sync2;
`else
   assign {hz, tr, td, br} = {hazard_req, turn_req, turn_dir, brake_req};
`endif

   // State register: mode, pattern phase, prescaler and registered brake
   always_ff @(posedge ADC_CLK_10 or posedge RESET) begin
      if (RESET) begin
         state   <= M_IDLE;
         phase   <= 2'd0;
         cnt     <= '0;
         brake_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         phase   <= phase_nxt;
         cnt     <= cnt_nxt;
         brake_q <= br;
      end
   end

   // Priority decode and next-state: a mode change restarts the pattern; brake never does
   always_comb begin
      decoded   = M_IDLE;
      state_nxt = state;
      phase_nxt = phase;
      cnt_nxt   = cnt;
      if (hz) begin
         decoded = M_HAZ;
      end else if (tr) begin
         decoded = td ? M_LEFT : M_RIGHT;
      end else begin
         decoded = M_IDLE;
      end

      if (decoded != state) begin
         state_nxt = decoded;
         phase_nxt = 2'd0;
         cnt_nxt   = '0;
      end else if (state == M_IDLE) begin
         phase_nxt = 2'd0;
         cnt_nxt   = '0;
      end else if (cnt == LAST) begin
         cnt_nxt   = '0;
         phase_nxt = (state == M_HAZ) ? (phase ^ 2'd1) : (phase + 2'd1);
      end else begin
         cnt_nxt = cnt + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   // Lamp patterns are a function of registered state only
   always_comb begin
      lamp_l = 3'b000;
      lamp_r = 3'b000;
      case (phase)
         2'd0:    turn_pat = 3'b001;
         2'd1:    turn_pat = 3'b011;
         2'd2:    turn_pat = 3'b111;
         default: turn_pat = 3'b000;
      endcase
      case (state)
         M_HAZ: begin
            lamp_l = (phase == 2'd0) ? 3'b111 : 3'b000;
            lamp_r = (phase == 2'd0) ? 3'b111 : 3'b000;
         end
         M_LEFT: begin
            lamp_l = turn_pat;
            lamp_r = brake_q ? 3'b111 : 3'b000;
         end
         M_RIGHT: begin
            lamp_l = brake_q ? 3'b111 : 3'b000;
            lamp_r = turn_pat;
         end
         default: begin
            lamp_l = brake_q ? 3'b111 : 3'b000;
            lamp_r = brake_q ? 3'b111 : 3'b000;
         end
      endcase
   end

   assign mode      = state;
   assign step_tick = (state != M_IDLE) && (cnt == LAST);

endmodule

// File: tb/tb_taillight_sequencer.sv
// Self-checking bench for taillight_sequencer (DIV=4, synchronizers disabled).
module tb_taillight_sequencer;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       hazard_req = 1'b0, turn_req = 1'b0, turn_dir = 1'b0, brake_req = 1'b0;
   logic [2:0] lamp_l, lamp_r;
   logic [1:0] mode;
   logic       step_tick;

   int tests = 0;
   int fails = 0;

   // Reference state: mode, cycles elapsed since the mode was entered, registered brake
   int m_mode = 0;
   int m_c    = 0;
   bit m_brake = 1'b0;

   taillight_sequencer #(.DIV(DIV), .CW(3)) dut (
      .ADC_CLK_10(clk), .RESET(rst),
      .hazard_req(hazard_req), .turn_req(turn_req), .turn_dir(turn_dir), .brake_req(brake_req),
      .lamp_l(lamp_l), .lamp_r(lamp_r), .mode(mode), .step_tick(step_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       h, t, d, b;
      logic [1:0] e_mode;
      logic [2:0] e_l, e_r;
      logic       e_tick;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_mode  = 0;
      m_c     = 0;
      m_brake = 1'b0;
   endfunction

   function automatic void model_edge(input bit h, input bit t, input bit d, input bit b);
      int dec;
      dec = h ? 1 : (t ? (d ? 2 : 3) : 0);
      if (dec != m_mode) begin
         m_mode = dec;
         m_c    = 0;
      end else if (m_mode != 0) begin
         m_c++;
      end
      m_brake = b;
   endfunction

   task automatic check_model(input string tag);
      logic [2:0] pats[4];
      logic [2:0] side, el, er;
      int steps;
      pats = '{3'b001, 3'b011, 3'b111, 3'b000};
      side = m_brake ? 3'b111 : 3'b000;
      steps = m_c / DIV;
      el = side;
      er = side;
      if (m_mode == 1) begin
         el = (steps % 2 == 0) ? 3'b111 : 3'b000;
         er = el;
      end else if (m_mode == 2) begin
         el = pats[steps % 4];
      end else if (m_mode == 3) begin
         er = pats[steps % 4];
      end
      check({tag, " mode"}, mode, m_mode);
      check({tag, " lamp_l"}, lamp_l, el);
      check({tag, " lamp_r"}, lamp_r, er);
      check({tag, " tick"}, step_tick, (m_mode != 0 && (m_c % DIV) == DIV - 1) ? 1 : 0);
   endtask

   task automatic edge_step();
      @(posedge clk);
      model_edge(hazard_req, turn_req, turn_dir, brake_req);
      #1;
   endtask

   task automatic set_in(input bit h, input bit t, input bit d, input bit b);
      hazard_req = h; turn_req = t; turn_dir = d; brake_req = b;
   endtask

   initial begin
      //           h     t     d     b     mode   lamp_l  lamp_r  tick
      vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 3'b001, 3'b000, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 3'b001, 3'b000, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 3'b001, 3'b000, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 3'b001, 3'b000, 1'b1};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 3'b011, 3'b000, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 3'b011, 3'b111, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 3'b111, 3'b111, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 3'b111, 3'b111, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 3'b000, 3'b001, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b111, 3'b111, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 3'b000, 1'b0};

      // Reset asserted between edges must blank outputs immediately
      #2 rst = 1'b1;
      #1;
      check("reset lamp_l", lamp_l, 3'b000);
      check("reset lamp_r", lamp_r, 3'b000);
      check("reset mode", mode, 2'b00);
      check("reset tick", step_tick, 1'b0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // Table vectors, one edge per entry
      for (int i = 0; i < 11; i++) begin
         set_in(vecs[i].h, vecs[i].t, vecs[i].d, vecs[i].b);
         edge_step();
         check($sformatf("vec%0d mode", i), mode, vecs[i].e_mode);
         check($sformatf("vec%0d lamp_l", i), lamp_l, vecs[i].e_l);
         check($sformatf("vec%0d lamp_r", i), lamp_r, vecs[i].e_r);
         check($sformatf("vec%0d tick", i), step_tick, vecs[i].e_tick);
      end

      // Full LEFT cycle; brake joins at edge 6 without restarting the pattern
      set_in(1'b0, 1'b1, 1'b1, 1'b0);
      for (int e = 0; e <= 16; e++) begin
         if (e == 6) brake_req = 1'b1;
         edge_step();
         if (e == 4)  check("left e4", lamp_l, 3'b011);
         if (e == 6)  check("brake e6 r", lamp_r, 3'b111);
         if (e == 8)  check("left e8", lamp_l, 3'b111);
         if (e == 12) check("left e12", lamp_l, 3'b000);
         if (e == 16) check("left e16", lamp_l, 3'b001);
      end

      // Reset mid-sequence at phase 2, requests held through release
      set_in(1'b0, 1'b1, 1'b1, 1'b0);
      for (int e = 0; e < 9; e++) edge_step();
      check("pre-reset phase2", lamp_l, 3'b111);
      #2 rst = 1'b1;
      #1;
      check("midseq reset l", lamp_l, 3'b000);
      check("midseq reset mode", mode, 2'b00);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      edge_step();
      check("restart l", lamp_l, 3'b001);
      for (int e = 0; e < 4; e++) edge_step();
      check("restart step", lamp_l, 3'b011);
      check_model("restart");

      // Randomized request patterns held for random spans, against the model
      for (int blk = 0; blk < 80; blk++) begin
         set_in($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
         for (int k = 0; k < $urandom_range(1, 12); k++) begin
            if (k > 0 && $urandom_range(0, 5) == 0) brake_req = ~brake_req;
            edge_step();
            check_model($sformatf("rand%0d", blk));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
